// File: rtl/opnd_sel_stage.sv
// Decode-to-execute operand stage: resolves ALU/AGU/CSR source selects and holds the result in the EX register.
// Optional one-entry skid buffer in front of the EX register when OPSEL_SKID_EN is defined.

`ifndef ALUSrcA_sel_width
`define ALUSrcA_sel_width 2
`define ALUSrcA_sel_rs1   2'd0
`define ALUSrcA_sel_pc    2'd1
`define ALUSrcA_sel_0     2'd2
`define ALUSrcA_sel_nop   2'd3
`endif

`ifndef ALUSrcB_sel_width
`define ALUSrcB_sel_width 2
`define ALUSrcB_sel_rs2   2'd0
`define ALUSrcB_sel_imm   2'd1
`define ALUSrcB_sel_4     2'd2
`define ALUSrcB_sel_nop   2'd3
`endif

`ifndef AGUSrc_sel_width
`define AGUSrc_sel_width  2
`define AGUSrc_sel_rs1    2'd0
`define AGUSrc_sel_pc     2'd1
`define AGUSrc_sel_nop    2'd2
`endif

`ifndef CSRSrc_sel_width
`define CSRSrc_sel_width  2
`define CSRSrc_sel_rs1    2'd0
`define CSRSrc_sel_imm    2'd1
`define CSRSrc_sel_nop    2'd2
`endif

module opnd_sel_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [`ALUSrcA_sel_width-1:0] alu_a_sel,
  input  logic [`ALUSrcB_sel_width-1:0] alu_b_sel,
  input  logic [`AGUSrc_sel_width-1:0]  agu_sel,
  input  logic [`CSRSrc_sel_width-1:0]  csr_sel,
  input  logic [XLEN-1:0]               rs1_data,
  input  logic [XLEN-1:0]               rs2_data,
  input  logic [XLEN-1:0]               pc,
  input  logic [XLEN-1:0]               imm,
  input  logic [4:0]                    zimm,
  input  logic [CTRL_W-1:0]             ctrl_in,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               alu_a,
  output logic [XLEN-1:0]               alu_b,
  output logic [XLEN-1:0]               agu_base,
  output logic [XLEN-1:0]               agu_off,
  output logic [XLEN-1:0]               csr_src,
  output logic [XLEN-1:0]               rs2_out,
  output logic [CTRL_W-1:0]             ctrl_out
);

  typedef struct packed {
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   agu_base;
    logic [XLEN-1:0]   agu_off;
    logic [XLEN-1:0]   csr_src;
    logic [XLEN-1:0]   rs2;
    logic [CTRL_W-1:0] ctrl;
  } opnd_t;

  opnd_t res;
  opnd_t m_q;
  logic  m_valid;
  logic  in_fire;
  logic  out_fire;
  logic  m_open;

  // Nop and unlisted select codes all resolve to zero.
  always_comb begin
    res = '0;
    case (alu_a_sel)
      `ALUSrcA_sel_rs1: res.alu_a = rs1_data;
      `ALUSrcA_sel_pc:  res.alu_a = pc;
      default:          res.alu_a = '0;
    endcase
    case (alu_b_sel)
      `ALUSrcB_sel_rs2: res.alu_b = rs2_data;
      `ALUSrcB_sel_imm: res.alu_b = imm;
      `ALUSrcB_sel_4:   res.alu_b = XLEN'(4);
      default:          res.alu_b = '0;
    endcase
    case (agu_sel)
      `AGUSrc_sel_rs1: res.agu_base = rs1_data;
      `AGUSrc_sel_pc:  res.agu_base = pc;
      default:         res.agu_base = '0;
    endcase
    case (csr_sel)
      `CSRSrc_sel_rs1: res.csr_src = rs1_data;
      `CSRSrc_sel_imm: res.csr_src = {{(XLEN-5){1'b0}}, zimm};
      default:         res.csr_src = '0;
    endcase
    res.agu_off = imm;
    res.rs2     = rs2_data;
    res.ctrl    = ctrl_in;
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload never change while waiting for ready, except on flush or reset.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign m_open   = !m_valid | out_fire;

`ifdef OPSEL_SKID_EN
  opnd_t s_q;
  logic  s_valid;

  // in_ready comes straight from a flop, so it never depends on out_ready this cycle.
  assign in_ready = !s_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_open) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        m_q     <= res;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && !m_open && in_fire) begin
      s_q <= res;
    end
  end
`else
  assign in_ready = m_open;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (m_open) begin
      m_valid <= in_fire;
      if (in_fire) begin
        m_q <= res;
      end
    end
  end
`endif

  assign out_valid = m_valid;
  assign alu_a     = m_q.alu_a;
  assign alu_b     = m_q.alu_b;
  assign agu_base  = m_q.agu_base;
  assign agu_off   = m_q.agu_off;
  assign csr_src   = m_q.csr_src;
  assign rs2_out   = m_q.rs2;
  assign ctrl_out  = m_q.ctrl;

endmodule
